// File: rtl/fmul32_pkg.sv
// Shared constants and stage payload for the FMUL32 result-pack back end.
package fmul32_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 23;
  localparam int SIG_W    = MANT_W + 1;
  localparam int PROD_W   = 48;
  localparam int STAGES   = 2;
  localparam logic [31:0] CANON_NAN_VAL = 32'h7FC0_0000;

  // Normalised/aligned operand handed from stage 1 to the rounder.
  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp;
    logic [SIG_W-1:0]  sig;
    logic              g;
    logic              r;
    logic              s;
    logic              tiny;
    logic              pre_ovf;
    logic              nan;
    logic              inf;
    logic              zero;
  } s1_pay_t;
endpackage

// File: rtl/fmul32_res_pack_if.sv
// Operand bundle in, packed result out; master drives bundles, slave is the pack stage.
interface fmul32_res_pack_if;
  import fmul32_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [9:0]        in_exp_tmp;
  logic [PROD_W-1:0] in_mant_prod;
  logic [7:0]        in_denorm_shift;
  logic              in_prev_inf;
  logic              in_prev_overflow;
  logic              in_nan;
  logic              in_inf;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_inexact;

  modport master (
    output in_valid, in_sign, in_exp_tmp, in_mant_prod, in_denorm_shift,
           in_prev_inf, in_prev_overflow, in_nan, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
  modport slave (
    input  in_valid, in_sign, in_exp_tmp, in_mant_prod, in_denorm_shift,
           in_prev_inf, in_prev_overflow, in_nan, in_inf, in_zero, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fmul32_round_rne.sv
// Combinational round-to-nearest-even on a 24-bit significand with G/R/S.
module fmul32_round_rne
  import fmul32_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic [SIG_W-1:0]  sig_i,
  input  logic              g_i,
  input  logic              r_i,
  input  logic              s_i,
  input  logic signed [9:0] exp_i,
  input  logic              tiny_i,
  output logic [MANT_W-1:0] frac_o,
  output logic signed [9:0] exp_o,
  output logic              inexact_o
);
  logic             inc;
  logic [SIG_W:0]   sum;

  always_comb begin
    inexact_o = g_i | r_i | s_i;
    inc       = ROUND_EN & g_i & (r_i | s_i | sig_i[0]);
    sum       = {1'b0, sig_i} + {{SIG_W{1'b0}}, inc};
    frac_o    = sum[MANT_W-1:0];
    exp_o     = exp_i;
    // A denormal that rounds up into the hidden bit becomes the smallest normal.
    if (tiny_i) begin
      exp_o = sum[SIG_W-1] ? 10'sd1 : 10'sd0;
    end else if (sum[SIG_W]) begin
      frac_o = '0;
      exp_o  = exp_i + 10'sd1;
    end
  end
endmodule

// File: rtl/fmul32_res_pack.sv
// FMUL32 back end: normalise/denormal-align (stage 1), round/pack (stage 2), elastic valid/ready.
module fmul32_res_pack
  import fmul32_pkg::*;
#(
  parameter bit          ROUND_EN  = 1'b1,
  parameter logic [31:0] CANON_NAN = CANON_NAN_VAL
) (
  input logic               clk,
  input logic               rst,
  fmul32_res_pack_if.slave  io
);
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  s1_pay_t           s1_q, s1_d, pay;
  logic [31:0]       res_q, res_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
  logic              s1_adv, s2_adv;
  logic              n;
  logic [7:0]        sh;
  logic [4:0]        shamt;
  logic [PROD_W-1:0] m, m_sh, lost_mask;
  logic [MANT_W-1:0] rnd_frac;
  logic signed [9:0] rnd_exp;
  logic              rnd_inx;

  assign s2_adv      = ~vld_pipe_q[2] | io.out_ready;
  assign s1_adv      = ~vld_pipe_q[1] | s2_adv;
  assign io.in_ready = ~rst & s1_adv;

  always_comb begin
    n     = io.in_mant_prod[PROD_W-1];
    m     = n ? io.in_mant_prod : {io.in_mant_prod[PROD_W-2:0], 1'b0};
    sh    = io.in_denorm_shift - {7'd0, n};
    shamt = 5'd0;
    if (io.in_denorm_shift != 8'd0 && sh != 8'd0)
      shamt = (sh > 8'd26) ? 5'd26 : sh[4:0];
    m_sh      = m >> shamt;
    lost_mask = ~({PROD_W{1'b1}} << shamt);

    pay.sign    = io.in_sign;
    pay.tiny    = (io.in_denorm_shift != 8'd0) && (sh != 8'd0);
    pay.exp     = pay.tiny ? 10'sd0 : $signed(io.in_exp_tmp) + $signed({9'd0, n});
    pay.sig     = m_sh[PROD_W-1 -: SIG_W];
    pay.g       = m_sh[PROD_W-SIG_W-1];
    pay.r       = m_sh[PROD_W-SIG_W-2];
    // Sticky covers both the low product bits and whatever the denormal shift pushed out.
    pay.s       = (|m_sh[PROD_W-SIG_W-3:0]) | (|(m & lost_mask));
    pay.pre_ovf = io.in_prev_overflow | io.in_prev_inf;
    pay.nan     = io.in_nan;
    pay.inf     = io.in_inf;
    pay.zero    = io.in_zero;

    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    if (s1_adv) vld_pipe_d[1] = io.in_valid & io.in_ready;
    if (io.in_valid & io.in_ready) s1_d = pay;
    if (s2_adv) vld_pipe_d[2] = vld_pipe_q[1];
  end

  fmul32_round_rne #(.ROUND_EN(ROUND_EN)) u_rnd (
    .sig_i     (s1_q.sig),
    .g_i       (s1_q.g),
    .r_i       (s1_q.r),
    .s_i       (s1_q.s),
    .exp_i     (s1_q.exp),
    .tiny_i    (s1_q.tiny),
    .frac_o    (rnd_frac),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inx)
  );

  always_comb begin
    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    inx_d = inx_q;
    if (s2_adv && vld_pipe_q[1]) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
      if (s1_q.nan || (s1_q.inf && s1_q.zero)) begin
        res_d = CANON_NAN;
      end else if (s1_q.inf) begin
        res_d = {s1_q.sign, 8'hFF, {MANT_W{1'b0}}};
      end else if (s1_q.zero) begin
        res_d = {s1_q.sign, 31'h0};
      end else if (s1_q.pre_ovf || (rnd_exp >= $signed(10'(EXP_MAX)))) begin
        res_d = {s1_q.sign, 8'hFF, {MANT_W{1'b0}}};
        ovf_d = 1'b1;
        inx_d = 1'b1;
      end else begin
        res_d = {s1_q.sign, rnd_exp[7:0], rnd_frac};
        inx_d = rnd_inx;
        unf_d = s1_q.tiny & rnd_inx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inx_q      <= inx_d;
    end
  end

  assign io.out_valid     = vld_pipe_q[2];
  assign io.out_result    = res_q;
  assign io.out_overflow  = ovf_q;
  assign io.out_underflow = unf_q;
  assign io.out_inexact   = inx_q;
endmodule

// File: tb/tb_fmul32_res_pack.sv
// Bench for fmul32_res_pack: RNE and truncating instances share one stimulus stream.
module tb_fmul32_res_pack;
  import fmul32_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [9:0]  et;
    logic [47:0] prod;
    logic        nan;
    logic        inf;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmul32_res_pack_if ifr ();
  fmul32_res_pack_if ift ();

  fmul32_res_pack #(.ROUND_EN(1'b1)) u_rne (.clk(clk), .rst(rst), .io(ifr.slave));
  fmul32_res_pack #(.ROUND_EN(1'b0)) u_trc (.clk(clk), .rst(rst), .io(ift.slave));

  assign ift.in_valid         = ifr.in_valid;
  assign ift.in_sign          = ifr.in_sign;
  assign ift.in_exp_tmp       = ifr.in_exp_tmp;
  assign ift.in_mant_prod     = ifr.in_mant_prod;
  assign ift.in_denorm_shift  = ifr.in_denorm_shift;
  assign ift.in_prev_inf      = ifr.in_prev_inf;
  assign ift.in_prev_overflow = ifr.in_prev_overflow;
  assign ift.in_nan           = ifr.in_nan;
  assign ift.in_inf           = ifr.in_inf;
  assign ift.in_zero          = ifr.in_zero;
  assign ift.out_ready        = ifr.out_ready;

  int   n_chk = 0;
  int   n_err = 0;
  int   pops_r = 0;
  vec_t cur;
  exp_t qr[$];
  exp_t qt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Value-level reference: divide the exact product by the ulp of the target format and round.
  function automatic exp_t model(input vec_t v, input bit rne);
    exp_t r;
    int et, p, e, sh;
    logic [63:0] prod, quo, rem, half;
    bit tiny, inc;
    r = '0;
    if (v.nan || (v.inf && v.zero)) begin r.res = 32'h7FC00000; return r; end
    if (v.inf)  begin r.res = {v.sign, 8'hFF, 23'h0}; return r; end
    if (v.zero) begin r.res = {v.sign, 31'h0}; return r; end
    et   = int'($signed(v.et));
    prod = {16'h0, v.prod};
    p    = v.prod[47] ? 47 : 46;
    e    = et + p - 46;
    tiny = (e < 1);
    sh   = tiny ? 24 - et : p - 23;
    if (sh >= 63) begin
      quo = 0; rem = prod; half = 64'h8000_0000_0000_0000;
    end else begin
      quo = prod >> sh; rem = prod & ((64'd1 << sh) - 64'd1); half = 64'd1 << (sh - 1);
    end
    inc   = rne && ((rem > half) || (rem == half && quo[0]));
    quo   = quo + 64'(inc);
    r.inx = (rem != 0);
    if (tiny) e = (quo >= 64'h80_0000) ? 1 : 0;
    else if (quo >= 64'h100_0000) begin e = e + 1; quo = quo >> 1; end
    if (e >= 255) begin
      r.res = {v.sign, 8'hFF, 23'h0}; r.ovf = 1'b1; r.inx = 1'b1; return r;
    end
    r.res = {v.sign, 8'(e), quo[22:0]};
    r.unf = tiny && r.inx;
    return r;
  endfunction

  function automatic vec_t mk(input logic s, input logic [9:0] et, input logic [47:0] pr,
                              input logic na, input logic inf, input logic z);
    vec_t v;
    v.sign = s; v.et = et; v.prod = pr; v.nan = na; v.inf = inf; v.zero = z;
    return v;
  endfunction

  task automatic set_in(input vec_t v);
    int e;
    e = int'($signed(v.et));
    cur = v;
    ifr.in_sign          = v.sign;
    ifr.in_exp_tmp       = v.et;
    ifr.in_mant_prod     = v.prod;
    ifr.in_denorm_shift  = (e <= 0) ? 8'(1 - e) : 8'd0;
    ifr.in_prev_inf      = (e == 255);
    ifr.in_prev_overflow = (e >= 256);
    ifr.in_nan           = v.nan;
    ifr.in_inf           = v.inf;
    ifr.in_zero          = v.zero;
  endtask

  // Returns #1 after the accepting edge.
  task automatic put(input vec_t v, output int stalls);
    set_in(v);
    ifr.in_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!ifr.in_ready && stalls < 50) begin stalls++; @(negedge clk); end
    if (!ifr.in_ready) begin
      n_chk++; n_err++;
      $display("FAIL put_timeout: in_ready got 0 want 1 after %0d cycles", stalls);
    end
    @(posedge clk); #1;
    ifr.in_valid = 1'b0;
  endtask

  // Scoreboard: every valid output cycle is checked against the model queue.
  always @(negedge clk) begin
    exp_t gr, gt;
    if (rst) begin
      qr.delete(); qt.delete();
    end else begin
      gr = {ifr.out_result, ifr.out_overflow, ifr.out_underflow, ifr.out_inexact};
      gt = {ift.out_result, ift.out_overflow, ift.out_underflow, ift.out_inexact};
      if (ifr.out_valid) begin
        if (qr.size() == 0) begin
          n_chk++; n_err++; $display("FAIL rne_spurious: got %h want no output", gr);
        end else begin
          chk("rne_stream", gr, qr[0]);
          if (ifr.out_ready) begin void'(qr.pop_front()); pops_r++; end
        end
      end
      if (ift.out_valid) begin
        if (qt.size() == 0) begin
          n_chk++; n_err++; $display("FAIL trc_spurious: got %h want no output", gt);
        end else begin
          chk("trc_stream", gt, qt[0]);
          if (ift.out_ready) void'(qt.pop_front());
        end
      end
      if (ifr.in_valid && ifr.in_ready) begin
        qr.push_back(model(cur, 1'b1));
        qt.push_back(model(cur, 1'b0));
      end
    end
  end

  localparam int NV = 13;
  vec_t  tv [NV];
  exp_t  ter[NV];
  exp_t  tet[NV];
  string tn [NV];

  task automatic run_lit(input int i);
    int s;
    put(tv[i], s);
    chk({tn[i], "_lat1"}, ifr.out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tn[i], "_lat2"}, ifr.out_valid, 1'b1);
    chk({tn[i], "_rne"}, {ifr.out_result, ifr.out_overflow, ifr.out_underflow, ifr.out_inexact}, ter[i]);
    chk({tn[i], "_trc"}, {ift.out_result, ift.out_overflow, ift.out_underflow, ift.out_inexact}, tet[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, tot, p0;
    tn[0]  = "mul1p5";     tv[0]  = mk(0, 10'd127, 48'h900000000000, 0, 0, 0); ter[0]  = {32'h40100000, 3'b000}; tet[0]  = {32'h40100000, 3'b000};
    tn[1]  = "denorm";     tv[1]  = mk(0, 10'h3FF, 48'h400000000000, 0, 0, 0); ter[1]  = {32'h00200000, 3'b000}; tet[1]  = {32'h00200000, 3'b000};
    tn[2]  = "ovf";        tv[2]  = mk(1, 10'h100, 48'h400000000000, 0, 0, 0); ter[2]  = {32'hFF800000, 3'b101}; tet[2]  = {32'hFF800000, 3'b101};
    tn[3]  = "rnd_carry";  tv[3]  = mk(0, 10'd127, 48'h7FFFFFC00000, 0, 0, 0); ter[3]  = {32'h40000000, 3'b001}; tet[3]  = {32'h3FFFFFFF, 3'b001};
    tn[4]  = "unf_sticky"; tv[4]  = mk(0, 10'h3FF, 48'h400000000001, 0, 0, 0); ter[4]  = {32'h00200000, 3'b011}; tet[4]  = {32'h00200000, 3'b011};
    tn[5]  = "den_to_nrm"; tv[5]  = mk(0, 10'd0,   48'h7FFFFFFFFFFF, 0, 0, 0); ter[5]  = {32'h00800000, 3'b011}; tet[5]  = {32'h007FFFFF, 3'b011};
    tn[6]  = "rnd_ovf";    tv[6]  = mk(0, 10'd254, 48'h7FFFFFC00000, 0, 0, 0); ter[6]  = {32'h7F800000, 3'b101}; tet[6]  = {32'h7F7FFFFF, 3'b001};
    tn[7]  = "tie_even";   tv[7]  = mk(0, 10'd127, 48'h400000400000, 0, 0, 0); ter[7]  = {32'h3F800000, 3'b001}; tet[7]  = {32'h3F800000, 3'b001};
    tn[8]  = "tie_odd";    tv[8]  = mk(0, 10'd127, 48'h400000C00000, 0, 0, 0); ter[8]  = {32'h3F800002, 3'b001}; tet[8]  = {32'h3F800001, 3'b001};
    tn[9]  = "inf_zero";   tv[9]  = mk(0, 10'd0,   48'h0,            0, 1, 1); ter[9]  = {32'h7FC00000, 3'b000}; tet[9]  = {32'h7FC00000, 3'b000};
    tn[10] = "inf";        tv[10] = mk(1, 10'd127, 48'h400000000000, 0, 1, 0); ter[10] = {32'hFF800000, 3'b000}; tet[10] = {32'hFF800000, 3'b000};
    tn[11] = "zero";       tv[11] = mk(1, 10'd127, 48'h0,            0, 0, 1); ter[11] = {32'h80000000, 3'b000}; tet[11] = {32'h80000000, 3'b000};
    tn[12] = "nan";        tv[12] = mk(0, 10'd127, 48'h900000000000, 1, 0, 0); ter[12] = {32'h7FC00000, 3'b000}; tet[12] = {32'h7FC00000, 3'b000};

    // Pin the model against the hand-derived literals.
    for (int i = 0; i < NV; i++) begin
      chk({"model_rne_", tn[i]}, model(tv[i], 1'b1), ter[i]);
      chk({"model_trc_", tn[i]}, model(tv[i], 1'b0), tet[i]);
    end

    ifr.in_valid = 1'b0;
    ifr.out_ready = 1'b1;
    set_in(tv[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", ifr.in_ready, 1'b0);
    chk("rst_out_valid", ifr.out_valid, 1'b0);
    chk("rst_out_word", {ifr.out_result, ifr.out_overflow, ifr.out_underflow, ifr.out_inexact}, 35'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", ifr.in_ready, 1'b1);

    for (int i = 0; i < NV; i++) run_lit(i);

    // Back-to-back burst with no backpressure: no stalls allowed.
    tot = 0;
    for (int i = 0; i < NV; i++) begin put(tv[i], s); tot += s; end
    chk("tput_stalls", tot, 0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: four bundles while the sink is stalled for three cycles.
    p0 = pops_r;
    ifr.out_ready = 1'b0;
    fork
      begin repeat (3) @(posedge clk); #1 ifr.out_ready = 1'b1; end
      begin
        int st;
        put(tv[0], st);
        put(tv[3], st);
        chk("bp_in_ready_low", ifr.in_ready, 1'b0);
        put(tv[8], st);
        put(tv[9], st);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_count", pops_r - p0, 4);
    chk("bp_drained", qr.size(), 0);

    // Reset with both stages full.
    ifr.out_ready = 1'b0;
    put(tv[1], s);
    put(tv[2], s);
    chk("pre_rst_full", ifr.out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", ifr.out_valid, 1'b0);
    chk("mid_rst_result", ifr.out_result, 32'h0);
    chk("mid_rst_in_ready", ifr.in_ready, 1'b0);
    rst = 1'b0;
    ifr.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_idle", ifr.out_valid, 1'b0);
    run_lit(0);
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fmul32_res_pack.md
Name: fmul32_res_pack

Overview:
- Back end of the FMUL32 datapath: consumes the exponent-analysis results and the raw 48-bit significand product, then produces the packed IEEE-754 single-precision result.
- Applies the 1-bit normalisation, the denormal right shift, round-to-nearest-even, and the overflow/infinity substitution.
- 2-stage elastic pipeline with valid/ready on both sides; sits between the significand multiplier and the FMUL32 output register.

Parameters:
ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (inexact flag still computed)
CANON_NAN, 32'h7FC00000, result word emitted for any NaN outcome

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand bundle valid
in_ready  output  1  bundle accepted when in_valid & in_ready
in_sign  input  1  result sign (sign_a ^ sign_b)
in_exp_tmp  input  10  tentative biased exponent e_a+e_b-127, 10-bit two's complement
in_mant_prod  input  48  product of the two 24-bit significands (hidden bits included); binary point between bits 46 and 45
in_denorm_shift  input  8  right shift for a denormal result, = 1-in_exp_tmp when exp_tmp <= 0, else 0
in_prev_inf  input  1  exp_tmp == 255
in_prev_overflow  input  1  exp_tmp in 256..511
in_nan, in_inf, in_zero  input  1 each  special-operand flags from the unpack stage
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_result  output  32  packed float
out_overflow, out_underflow, out_inexact  output  1 each  exception flags, aligned with out_result

Behaviour:
- Reset, synchronous, active-high:
  - Both stage valids clear; out_valid=0; out_result=0; all flags 0.
  - in_ready=0 while rst is high, 1 the cycle after.
  - Any bundles in flight when reset asserts are discarded; no partial output.
- Handshake:
  - Stage k advances when its output register is empty or being consumed.
  - in_ready = ~s1_valid | (~s2_valid | out_ready).
  - Full throughput: one bundle per cycle. Latency is exactly 2 cycles from acceptance to out_valid when out_ready=1.
  - out_result and the flags hold stable while out_valid & ~out_ready. Order is preserved.
- Stage 1 (normalise / align):
  - n = in_mant_prod[47].
  - exp_n = in_exp_tmp + n, 10-bit signed.
  - Normalised significand m = n ? prod[47:0] : prod[46:0]<<1.
  - denormal when in_denorm_shift != 0. Effective shift sh = in_denorm_shift - n.
    - sh==0: result is normal, exponent field 1.
    - sh>0: right-shift m by min(sh,26); every bit shifted out ORs into sticky; exponent field 0.
  - Capture the 24-bit kept significand plus guard, round, and sticky bits (sticky also ORs the low product bits).
- Stage 2 (round / pack):
  - RNE increments when G & (R | S | lsb). If ROUND_EN=0, no increment.
  - Carry out of a normal significand gives exp+1 and significand 1.0.
  - Carry from a denormal into bit 23 gives exponent field 1 (becomes normal).
  - inexact = G|R|S.
  - overflow = in_prev_overflow | in_prev_inf | (final exp >= 255). Result = {sign, 8'hFF, 23'h0}; overflow=1, inexact=1.
  - underflow = tiny-before-rounding (denormal path) & inexact.
- Special priority, highest first:
  1. in_nan, or in_inf & in_zero: CANON_NAN, all flags 0.
  2. in_inf: {sign, 8'hFF, 0}.
  3. in_zero: {sign, 31'h0}.
  4. Arithmetic path.
- Simultaneous in_valid and out_ready with both stages full: the pipeline shifts and accepts in the same cycle, with no bubble.

Decomposition:
- Shared package fmul32_pkg holds:
  - Constants: EXP_BIAS=127, EXP_MAX=255, MANT_W=23, PROD_W=48, the canonical NaN value.
  - Typedef for the stage-1 payload: sign, exp, 24-bit significand, G, R, S, special flags.
- One sub-module: fmul32_round_rne. It is combinational: takes significand, G, R, S, exponent and denormal flag; returns rounded significand, exponent and inexact. Instantiated in stage 2.

Test Plan:
- 1.5×1.5: exp_tmp=127, prod=48'h900000000000 -> out_result=32'h40100000, flags 0, out_valid 2 cycles after accept.
- Denormal: exp_tmp=10'h3FF, prod=48'h400000000000, denorm_shift=2 -> 32'h00200000, underflow=0, inexact=0.
- Overflow: exp_tmp=10'h100, prev_overflow=1, sign=1 -> 32'hFF800000, overflow=1, inexact=1.
- Rounding carry: exp_tmp=127, prod=48'h7FFFFFC00000 -> 32'h40000000, inexact=1. Same with ROUND_EN=0 -> 32'h3FFFFFFF.
- Backpressure: 4 back-to-back bundles with out_ready low for 3 cycles. in_ready drops after 2 are held; all 4 results appear in order with no loss or duplication. in_inf & in_zero -> 32'h7FC00000.
- Reset mid-operation: rst asserted with both stages valid -> next cycle out_valid=0 and out_result=0. Post-reset bundle -> correct result at latency 2.
